// File: rtl/test_pattern_gen.sv
// Inline RGB test-pattern generator/overlay with per-frame shadowed configuration.
// Latency 1 cycle on every output; no backpressure, a pixel may arrive every cycle.
module test_pattern_gen #(
  parameter int W        = 10,
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1280,
  parameter int CHK_LOG  = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     mode_i,
  input  logic [CW-1:0]  box_x0_i,
  input  logic [CW-1:0]  box_x1_i,
  input  logic [CW-1:0]  box_y0_i,
  input  logic [CW-1:0]  box_y1_i,
  input  logic [3*W-1:0] box_rgb_i,
  input  logic           anim_en_i,
  input  logic           sop_i,
  input  logic           eop_i,
  input  logic           valid_i,
  input  logic [W-1:0]   r_i,
  input  logic [W-1:0]   g_i,
  input  logic [W-1:0]   b_i,
  output logic           sop_o,
  output logic           eop_o,
  output logic           valid_o,
  output logic [W-1:0]   r_o,
  output logic [W-1:0]   g_o,
  output logic [W-1:0]   b_o,
  output logic [15:0]    frame_cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [W-1:0]  FULL    = '1;

  logic [CW-1:0]  col, line, col_n, line_n;
  logic           first_line;
  logic [15:0]    frame_cnt;

  logic [2:0]     mode_s;
  logic [CW-1:0]  x0_s, x1_s, y0_s, y1_s;
  logic [3*W-1:0] rgb_s;
  logic           anim_s;

  logic [CW:0]    off_w, bx0, bx1, col_w;
  logic           hit;
  logic [2:0]     bar;
  logic [3*W-1:0] pix;

  // Counters as seen by the current pixel, so the sop pixel is already col 0.
  always_comb begin
    col_n  = col;
    line_n = line;
    if (valid_i) begin
      if (sop_i) begin
        col_n = '0;
        if (first_line)
          line_n = '0;
        else if (line != CNT_MAX)
          line_n = line + CW'(1);
      end else if (col != CNT_MAX) begin
        col_n = col + CW'(1);
      end
    end
  end

  // Box bounds are widened by one bit so the animation offset never wraps.
  always_comb begin
    off_w = anim_s ? (CW+1)'(frame_cnt[7:0]) : '0;
    bx0   = {1'b0, x0_s} + off_w;
    bx1   = {1'b0, x1_s} + off_w;
    col_w = {1'b0, col_n};
    hit   = (col_w >= bx0) && (col_w <= bx1) &&
            (line_n >= y0_s) && (line_n <= y1_s);
  end

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(col_n) >= (k * H_ACTIVE) / 8)
        bar = 3'(k);
    end
  end

  // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
  always_comb begin
    pix = {r_i, g_i, b_i};
    if (valid_i) begin
      case (mode_s)
        3'd1: if (hit) pix = rgb_s;
        3'd2: pix = {{W{~bar[1]}}, {W{~bar[2]}}, {W{~bar[0]}}};
        3'd3: pix = (col_n[CHK_LOG] ^ line_n[CHK_LOG]) ? '0 : {3{FULL}};
        3'd4: pix = {3{col_n[W-1:0]}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      valid_o    <= 1'b0;
      r_o        <= '0;
      g_o        <= '0;
      b_o        <= '0;
      col        <= '0;
      line       <= '0;
      first_line <= 1'b1;
      frame_cnt  <= '0;
      mode_s     <= '0;
      x0_s       <= '0;
      x1_s       <= '0;
      y0_s       <= '0;
      y1_s       <= '0;
      rgb_s      <= '0;
      anim_s     <= 1'b0;
    end else begin
      sop_o             <= sop_i;
      eop_o             <= eop_i;
      valid_o           <= valid_i;
      {r_o, g_o, b_o}   <= pix;
      if (valid_i) begin
        col  <= col_n;
        line <= line_n;
        if (eop_i)
          first_line <= 1'b1;
        else if (sop_i)
          first_line <= 1'b0;
        if (eop_i) begin
          frame_cnt <= frame_cnt + 16'd1;
          mode_s    <= mode_i;
          x0_s      <= box_x0_i;
          x1_s      <= box_x1_i;
          y0_s      <= box_y0_i;
          y1_s      <= box_y1_i;
          rgb_s     <= box_rgb_i;
          anim_s    <= anim_en_i;
        end
      end
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: directed frames, expected pixels queued at issue time.
module tb_test_pattern_gen;

  localparam int K_PASS = 0, K_BOX = 1, K_ANIM = 2, K_BARS = 3, K_CHK = 4, K_RAMP = 5;
  localparam logic [29:0] BOXC  = {10'd1023, 10'd0, 10'd512};
  localparam logic [29:0] ANIMC = {10'd100, 10'd200, 10'd300};

  logic        clk, reset;
  logic [2:0]  mode_i;
  logic [11:0] box_x0_i, box_x1_i, box_y0_i, box_y1_i;
  logic [29:0] box_rgb_i;
  logic        anim_en_i, sop_i, eop_i, valid_i;
  logic [9:0]  r_i, g_i, b_i;
  logic        sop_o, eop_o, valid_o;
  logic [9:0]  r_o, g_o, b_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [31:0] sb[$];

  logic [2:0]  p_mode;
  logic        p_anim, p_vld;
  logic [11:0] p_x0, p_x1, p_y0, p_y1;
  logic [29:0] p_rgb;

  test_pattern_gen #(.W(10), .CW(12), .H_ACTIVE(16), .CHK_LOG(1)) dut (
    .clk(clk), .reset(reset), .mode_i(mode_i),
    .box_x0_i(box_x0_i), .box_x1_i(box_x1_i), .box_y0_i(box_y0_i), .box_y1_i(box_y1_i),
    .box_rgb_i(box_rgb_i), .anim_en_i(anim_en_i),
    .sop_i(sop_i), .eop_i(eop_i), .valid_i(valid_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] bar_rgb(input int k);
    case (k)
      0: return {10'h3FF, 10'h3FF, 10'h3FF};
      1: return {10'h3FF, 10'h3FF, 10'h000};
      2: return {10'h000, 10'h3FF, 10'h3FF};
      3: return {10'h000, 10'h3FF, 10'h000};
      4: return {10'h3FF, 10'h000, 10'h3FF};
      5: return {10'h3FF, 10'h000, 10'h000};
      6: return {10'h000, 10'h000, 10'h3FF};
      default: return 30'h0;
    endcase
  endfunction

  function automatic logic [29:0] expect_px(input int kind, input int n, input int l,
                                            input int c, input logic [29:0] din);
    logic [29:0] e;
    e = din;
    case (kind)
      K_BOX:  if (c >= 3 && c <= 5 && l >= 1 && l <= 2) e = BOXC;
      K_ANIM: if (c == n && l >= 1 && l <= 2) e = ANIMC;
      K_BARS: e = bar_rgb(c / 2);
      K_CHK:  e = ((((c >> 1) ^ (l >> 1)) & 1) == 0) ? {3{10'h3FF}} : 30'h0;
      K_RAMP: e = {3{10'(c)}};
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pix(input logic s, input logic e, input logic [29:0] d, input logic [29:0] x);
    @(negedge clk);
    sop_i = s;
    eop_i = e;
    valid_i = 1'b1;
    {r_i, g_i, b_i} = d;
    sb.push_back({s, e, x});
    pushed++;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      valid_i = 1'b0;
      sop_i = 1'b0;
      eop_i = 1'b0;
      {r_i, g_i, b_i} = 30'($urandom);
    end
  endtask

  task automatic apply_pending();
    mode_i = p_mode;
    anim_en_i = p_anim;
    box_x0_i = p_x0;
    box_x1_i = p_x1;
    box_y0_i = p_y0;
    box_y1_i = p_y1;
    box_rgb_i = p_rgb;
    p_vld = 1'b0;
  endtask

  // Pending config lands on the input ports halfway through the frame.
  task automatic send_frame(input int lines, input int cols, input int kind,
                            input int n, input int gap_at);
    int idx;
    logic [29:0] d;
    idx = 0;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < cols; c++) begin
        if (idx == gap_at) idle(3);
        if (idx == (lines * cols) / 2 && p_vld) apply_pending();
        d = 30'($urandom);
        pix(c == 0, (l == lines - 1) && (c == cols - 1), d, expect_px(kind, n, l, c, d));
        idx++;
      end
    end
    idle(1);
  endtask

  task automatic set_pending(input logic [2:0] m, input logic a, input logic [11:0] x0,
                             input logic [11:0] x1, input logic [11:0] y0,
                             input logic [11:0] y1, input logic [29:0] rgb);
    p_mode = m; p_anim = a; p_x0 = x0; p_x1 = x1; p_y0 = y0; p_y1 = y1; p_rgb = rgb;
    p_vld = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [31:0] e;
    #2;
    if (!reset && valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got %0h want none", {sop_o, eop_o, r_o, g_o, b_o});
      end else begin
        e = sb.pop_front();
        popped++;
        if ({sop_o, eop_o, r_o, g_o, b_o} !== e) begin
          errors++;
          $display("FAIL pixel#%0d got %0h want %0h", popped, {sop_o, eop_o, r_o, g_o, b_o}, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    mode_i = 3'd0; anim_en_i = 1'b0;
    box_x0_i = '0; box_x1_i = '0; box_y0_i = '0; box_y1_i = '0; box_rgb_i = '0;
    sop_i = 1'b0; eop_i = 1'b0; valid_i = 1'b0;
    r_i = '0; g_i = '0; b_i = '0;
    p_vld = 1'b0; p_mode = '0; p_anim = 1'b0;
    p_x0 = '0; p_x1 = '0; p_y0 = '0; p_y1 = '0; p_rgb = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_flags", 32'({sop_o, eop_o}), 32'd0);
    check("reset_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt_o), 32'd0);
    reset = 1'b0;
    idle(2);

    // Passthrough, two frames.
    send_frame(4, 16, K_PASS, 0, -1);
    send_frame(4, 16, K_PASS, 0, -1);
    check("frame_cnt_after_pass", 32'(frame_cnt_o), 32'd2);

    // Partial frame then asynchronous reset.
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 16; c++) begin
        logic [29:0] d;
        d = 30'($urandom) | 30'h1;
        pix(c == 0, 1'b0, d, d);
      end
    @(posedge clk);
    #3;
    reset = 1'b1;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    #1;
    check("midreset_valid", 32'(valid_o), 32'd0);
    check("midreset_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    check("midreset_frame_cnt", 32'(frame_cnt_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Animation config applies from frame 1; frame 0 after reset stays pass.
    mode_i = 3'd1; anim_en_i = 1'b1;
    box_x0_i = 12'd0; box_x1_i = 12'd0; box_y0_i = 12'd1; box_y1_i = 12'd2;
    box_rgb_i = ANIMC;
    send_frame(4, 16, K_PASS, 0, -1);
    send_frame(4, 16, K_ANIM, 1, -1);
    send_frame(4, 16, K_ANIM, 2, -1);
    set_pending(3'd1, 1'b0, 12'd3, 12'd5, 12'd1, 12'd2, BOXC);
    send_frame(4, 16, K_ANIM, 3, -1);
    check("frame_cnt_after_anim", 32'(frame_cnt_o), 32'd4);

    // Box frame; mid-frame switch to bars must not affect it.
    set_pending(3'd2, 1'b0, 12'd3, 12'd5, 12'd1, 12'd2, BOXC);
    send_frame(4, 16, K_BOX, 0, -1);
    set_pending(3'd3, 1'b0, 12'd3, 12'd5, 12'd1, 12'd2, BOXC);
    send_frame(1, 16, K_BARS, 0, -1);
    // Checkerboard with a 3-cycle gap mid-line 1.
    set_pending(3'd4, 1'b0, 12'd3, 12'd5, 12'd1, 12'd2, BOXC);
    send_frame(4, 8, K_CHK, 0, 11);
    set_pending(3'd5, 1'b0, 12'd3, 12'd5, 12'd1, 12'd2, BOXC);
    send_frame(1, 16, K_RAMP, 0, -1);
    send_frame(1, 4, K_PASS, 0, -1);
    check("frame_cnt_final", 32'(frame_cnt_o), 32'd9);

    idle(3);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("pixels_seen", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
